// File: rtl/qracc_pkg.sv
// Shared drain-state type and chunk geometry helpers
// for the qracc output write path.
package qracc_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } drain_state_t;

   localparam int DEF_ELEMENT_BITS = 8;
   localparam int DEF_IF_WIDTH     = 128;
   localparam int DEF_IE           = DEF_IF_WIDTH / DEF_ELEMENT_BITS;

   function automatic int lanes_per_chunk(input int if_width, input int elem_bits);
      return if_width / elem_bits;
   endfunction

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/qracc_sync_fifo.sv
// Synchronous FIFO with count; power-of-two depth so
// pointers wrap by natural overflow.
module qracc_sync_fifo #(
   parameter int width = 8,
   parameter int depth = 4,
   localparam int aw = $clog2(depth)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             clear,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output logic [width-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [aw:0]      count
);

   logic [width-1:0] mem [depth];
   logic [aw-1:0]    wr_ptr;
   logic [aw-1:0]    rd_ptr;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage carries no reset; validity is tracked by count
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign full     = (count == (aw+1)'(depth));
   assign empty    = (count == '0);

endmodule

// File: rtl/qracc_output_write_queue.sv
// Buffers qracc result vectors and drains each one into the
// activation buffer as masked interface-width chunks.
module qracc_output_write_queue
   import qracc_pkg::*;
#(
   parameter int numCols                = 256,
   parameter int elementBits            = 8,
   parameter int internalInterfaceWidth = 128,
   parameter int queueDepth             = 4,
   localparam int ie      = lanes_per_chunk(internalInterfaceWidth, elementBits),
   localparam int data_w  = numCols * elementBits,
   localparam int entry_w = data_w + 32,
   localparam int max_n   = ceil_div(numCols, ie),
   localparam int jw      = (max_n > 1) ? $clog2(max_n) : 1,
   localparam int aw      = $clog2(queueDepth)
) (
   input  logic                              clk,
   input  logic                              nrst,
   input  logic                              clear,
   input  logic                              start,
   input  logic [31:0]                       ofmap_base_addr,
   input  logic [15:0]                       num_output_channels,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [data_w-1:0]                 in_data,
   output logic                              wr_en,
   input  logic                              wr_ready,
   output logic [31:0]                       wr_addr,
   output logic [internalInterfaceWidth-1:0] wr_data,
   output logic [ie-1:0]                     wr_byte_en,
   output logic                              queue_valid,
   output logic                              cfg_err
);

   drain_state_t state, state_nxt;

   logic [31:0]       pix_ptr;
   logic [jw-1:0]     j;
   logic [31:0]       c32;
   logic [31:0]       j32;
   logic [31:0]       n_chunks;
   logic              c_bad;
   logic              push;
   logic              pop;
   logic              accept;
   logic              last_chunk;
   logic              drain_end;
   logic              fifo_full;
   logic              fifo_empty;
   logic [aw:0]       fifo_count;
   logic [entry_w-1:0] head;
   logic [data_w-1:0] head_data;
   logic [31:0]       head_addr;
   logic [internalInterfaceWidth-1:0] chunk;

   assign c32      = {16'd0, num_output_channels};
   assign c_bad    = (c32 == 32'd0) || (c32 > 32'(numCols));
   assign n_chunks = (c32 + 32'(ie) - 32'd1) / 32'(ie);
   assign j32      = 32'(j);

   // a bad channel count swallows the request instead of stalling
   assign in_ready   = c_bad || !fifo_full;
   assign push       = in_valid && in_ready && !c_bad && !clear;
   assign accept     = wr_en && wr_ready;
   assign last_chunk = (j32 == n_chunks - 32'd1);
   assign pop        = accept && last_chunk;
   assign drain_end  = pop && (fifo_count == (aw+1)'(1)) && !push;

   qracc_sync_fifo #(
      .width (entry_w),
      .depth (queueDepth)
   ) u_fifo (
      .clk       (clk),
      .nrst      (nrst),
      .clear     (clear),
      .push      (push),
      .push_data ({in_data, pix_ptr}),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign head_addr = head[31:0];
   assign head_data = head[entry_w-1:32];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= S_IDLE;
      end else if (clear) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (!fifo_empty && !drain_end) state_nxt = S_DRAIN;
         S_DRAIN: if (drain_end) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // head is presented as soon as it lands, giving one-cycle latency
   always_comb begin
      wr_en       = !fifo_empty && !clear;
      queue_valid = (fifo_count != '0) || (state == S_DRAIN);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         j       <= '0;
         pix_ptr <= '0;
         cfg_err <= 1'b0;
      end else if (clear) begin
         j       <= '0;
         pix_ptr <= '0;
         cfg_err <= 1'b0;
      end else begin
         if (accept) j <= last_chunk ? '0 : j + 1'b1;
         if (start) pix_ptr <= ofmap_base_addr;
         else if (push) pix_ptr <= pix_ptr + c32;
         if (in_valid && c_bad) cfg_err <= 1'b1;
      end
   end

   assign chunk   = head_data[j32*32'(internalInterfaceWidth) +: internalInterfaceWidth];
   assign wr_addr = head_addr + j32 * 32'(ie);

   always_comb begin
      wr_byte_en = '0;
      wr_data    = '0;
      for (int i = 0; i < ie; i++) begin
         if (wr_en && (j32 * 32'(ie) + 32'(i) < c32)) begin
            wr_byte_en[i] = 1'b1;
            wr_data[i*elementBits +: elementBits] = chunk[i*elementBits +: elementBits];
         end
      end
   end

endmodule

// File: tb/tb_qracc_output_write_queue.sv
// Self-checking bench for qracc_output_write_queue: scenario
// table plus hand sequences, scoreboard of expected writes.
module tb_qracc_output_write_queue;

   localparam int NC = 256;
   localparam int EB = 8;
   localparam int IW = 128;
   localparam int QD = 4;
   localparam int IE = IW / EB;
   localparam int DW = NC * EB;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          clear = 1'b0;
   logic          start = 1'b0;
   logic [31:0]   base = '0;
   logic [15:0]   c = 16'd16;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          wr_en;
   logic          wr_ready = 1'b0;
   logic [31:0]   wr_addr;
   logic [IW-1:0] wr_data;
   logic [IE-1:0] wr_byte_en;
   logic          queue_valid;
   logic          cfg_err;

   qracc_output_write_queue #(
      .numCols                (NC),
      .elementBits            (EB),
      .internalInterfaceWidth (IW),
      .queueDepth             (QD)
   ) dut (
      .clk                 (clk),
      .nrst                (nrst),
      .clear               (clear),
      .start               (start),
      .ofmap_base_addr     (base),
      .num_output_channels (c),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_data             (in_data),
      .wr_en               (wr_en),
      .wr_ready            (wr_ready),
      .wr_addr             (wr_addr),
      .wr_data             (wr_data),
      .wr_byte_en          (wr_byte_en),
      .queue_valid         (queue_valid),
      .cfg_err             (cfg_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int rdy_mode = 0;
   logic [31:0] model_ptr = '0;

   typedef struct {
      logic [31:0] addr;
      logic [IW-1:0] data;
      logic [IE-1:0] be;
   } wr_t;
   wr_t sb[$];

   typedef struct {
      int c;
      logic [31:0] base;
      int npush;
      int mode;
      int exp_wr;
   } vec_t;
   vec_t tbl[5];

   task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // wr_ready: 0 = always ready, 1 = toggling, 2 = stalled
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: wr_ready = 1'b1;
         1: wr_ready = ~wr_ready;
         default: wr_ready = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (nrst && wr_en && wr_ready) begin
         wr_t e;
         wr_count++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%0h required=none", wr_addr);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", IW'(wr_addr), IW'(e.addr));
            chk("wr_data", wr_data, e.data);
            chk("wr_byte_en", IW'(wr_byte_en), IW'(e.be));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] gen_data();
      logic [DW-1:0] d;
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic enqueue_model(input logic [DW-1:0] d);
      int n;
      n = (int'(c) + IE - 1) / IE;
      for (int ch = 0; ch < n; ch++) begin
         wr_t e;
         e.addr = model_ptr + 32'(ch * IE);
         e.data = '0;
         e.be   = '0;
         for (int i = 0; i < IE; i++) begin
            if (ch * IE + i < int'(c)) begin
               e.be[i] = 1'b1;
               e.data[i*EB +: EB] = d[(ch*IE + i)*EB +: EB];
            end
         end
         sb.push_back(e);
      end
      model_ptr = model_ptr + 32'(c);
   endtask

   task automatic do_push(input logic [DW-1:0] d, input bit expect_ok);
      bit ok;
      ok = 1'b0;
      in_data  = d;
      in_valid = 1'b1;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      in_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL push_timeout actual=stalled required=accepted");
      end else if (expect_ok) begin
         enqueue_model(d);
      end
   endtask

   task automatic wait_idle(input string nm);
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (!queue_valid) break;
      end
      chk(nm, IW'(queue_valid), '0);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_ptr = '0;
   endtask

   task automatic pulse_start(input logic [31:0] b);
      base  = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      model_ptr = b;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int w0;
      tbl[0] = '{c: 32,  base: 32'h100,      npush: 1, mode: 0, exp_wr: 2};
      tbl[1] = '{c: 20,  base: 32'h100,      npush: 2, mode: 0, exp_wr: 4};
      tbl[2] = '{c: 256, base: 32'hFFFF_FFF0, npush: 2, mode: 1, exp_wr: 32};
      tbl[3] = '{c: 1,   base: 32'h40,       npush: 3, mode: 1, exp_wr: 3};
      tbl[4] = '{c: 17,  base: 32'h0,        npush: 5, mode: 0, exp_wr: 10};

      #3;
      chk("rst_in_ready", IW'(in_ready), IW'(1));
      chk("rst_wr_en", IW'(wr_en), '0);
      chk("rst_queue_valid", IW'(queue_valid), '0);
      chk("rst_cfg_err", IW'(cfg_err), '0);
      chk("rst_byte_en", IW'(wr_byte_en), '0);
      tick();
      nrst = 1'b1;
      tick();

      // first write one cycle after push into an empty queue
      rdy_mode = 0;
      c = 16'd32;
      pulse_clear();
      pulse_start(32'h100);
      do_push(gen_data(), 1'b1);
      chk("first_wr_latency", IW'(wr_en), IW'(1));
      chk("first_wr_addr", IW'(wr_addr), IW'(32'h100));
      wait_idle("latency_drain_idle");

      foreach (tbl[t]) begin
         rdy_mode = tbl[t].mode;
         c = 16'(tbl[t].c);
         pulse_clear();
         pulse_start(tbl[t].base);
         w0 = wr_count;
         for (int p = 0; p < tbl[t].npush; p++) do_push(gen_data(), 1'b1);
         wait_idle("tbl_idle");
         chk("tbl_write_count", IW'(wr_count - w0), IW'(tbl[t].exp_wr));
         chk("tbl_sb_empty", IW'(sb.size()), '0);
      end

      // full queue under backpressure, outputs held
      rdy_mode = 2;
      c = 16'd16;
      pulse_clear();
      tick();
      pulse_start(32'h200);
      w0 = wr_count;
      for (int p = 0; p < QD; p++) do_push(gen_data(), 1'b1);
      in_data  = gen_data();
      in_valid = 1'b1;
      @(negedge clk);
      chk("full_in_ready", IW'(in_ready), '0);
      tick();
      tick();
      tick();
      @(negedge clk);
      chk("full_in_ready_hold", IW'(in_ready), '0);
      chk("hold_wr_en", IW'(wr_en), IW'(1));
      chk("hold_addr", IW'(wr_addr), IW'(sb[0].addr));
      chk("hold_data", wr_data, sb[0].data);
      chk("hold_be", IW'(wr_byte_en), IW'(sb[0].be));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rdy_mode = 0;
      wait_idle("full_drain_idle");
      chk("full_write_count", IW'(wr_count - w0), IW'(QD));

      // clear mid-drain with three entries pending
      rdy_mode = 2;
      c = 16'd32;
      pulse_clear();
      tick();
      pulse_start(32'h300);
      for (int p = 0; p < 3; p++) do_push(gen_data(), 1'b1);
      w0 = wr_count;
      clear = 1'b1;
      #1;
      chk("clear_wr_en_same_cycle", IW'(wr_en), '0);
      chk("clear_be_same_cycle", IW'(wr_byte_en), '0);
      tick();
      clear = 1'b0;
      sb.delete();
      chk("clear_queue_valid", IW'(queue_valid), '0);
      chk("clear_in_ready", IW'(in_ready), IW'(1));
      rdy_mode = 0;
      repeat (6) tick();
      chk("clear_no_writes", IW'(wr_count - w0), '0);

      // illegal channel counts
      for (int v = 0; v < 2; v++) begin
         c = (v == 0) ? 16'd0 : 16'd300;
         pulse_clear();
         pulse_start(32'h400);
         w0 = wr_count;
         do_push(gen_data(), 1'b0);
         chk("cfg_err_set", IW'(cfg_err), IW'(1));
         repeat (4) tick();
         chk("cfg_err_sticky", IW'(cfg_err), IW'(1));
         chk("cfg_no_writes", IW'(wr_count - w0), '0);
         chk("cfg_queue_valid", IW'(queue_valid), '0);
         pulse_clear();
         chk("cfg_err_cleared", IW'(cfg_err), '0);
      end

      // reset mid-drain abandons the partial write
      rdy_mode = 2;
      c = 16'd48;
      pulse_clear();
      tick();
      pulse_start(32'h500);
      do_push(gen_data(), 1'b1);
      do_push(gen_data(), 1'b1);
      w0 = wr_count;
      #2;
      nrst = 1'b0;
      #1;
      chk("rst_mid_wr_en", IW'(wr_en), '0);
      chk("rst_mid_queue_valid", IW'(queue_valid), '0);
      sb.delete();
      tick();
      nrst = 1'b1;
      rdy_mode = 0;
      repeat (6) tick();
      chk("rst_mid_no_writes", IW'(wr_count - w0), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
